// File: rtl/fw_hdr_lookup_pkg.sv
// Shared constants and FSM encoding for the firewall header-lookup front end.
package fw_hdr_lookup_pkg;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [3:0]  IP_VERSION_4 = 4'd4;

    // Data-word indices (ctrl=0 words, counted from 0)
    localparam logic [2:0] WORD_ETHTYPE = 3'd1;
    localparam logic [2:0] WORD_KEY     = 3'd3;
    localparam logic [2:0] WORD_KEY_LO  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REQ,
        S_WAIT,
        S_TAIL,
        S_EMIT
    } state_t;

endpackage

// File: rtl/fw_hdr_lookup.sv
// Snoops the packet stream, extracts an IPv4 address key, runs one TCAM compare
// per packet and writes exactly one result bit per packet, in packet order.
module fw_hdr_lookup
    import fw_hdr_lookup_pkg::*;
#(
    parameter int   DATA_WIDTH     = 64,
    parameter int   CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int   KEY_SEL        = 0,
    parameter logic NON_IP_RESULT  = 1'b0,
    parameter int   TIMEOUT_CYCLES = 16,
    parameter logic TIMEOUT_RESULT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic                  lookup_req,
    output logic [31:0]           lookup_key,
    input  logic                  lookup_busy,
    input  logic                  lookup_done,
    input  logic                  lookup_hit,
    output logic                  out_result,
    output logic                  out_result_wr,
    input  logic                  out_result_rdy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state, state_n;
    logic [2:0]      wcnt, wcnt_n;
    logic            eop_seen, eop_n;
    logic [31:0]     key_n;
    logic            req_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            res_n, wr_n;

    logic acc, is_data, data_acc, eop_now;
    logic launch, resolved, finish;
    logic unused_data;

    assign unused_data = ^in_data;

    // Stall the stream after EOP so only one packet's result is ever pending
    assign in_rdy   = ~reset & ~eop_seen;
    assign acc      = in_wr & in_rdy;
    assign is_data  = (in_ctrl == '0);
    assign data_acc = acc & is_data;
    assign eop_now  = acc & ~is_data & (state != S_IDLE);

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        eop_n    = eop_seen;
        key_n    = lookup_key;
        req_n    = 1'b0;
        tcnt_n   = tcnt;
        res_n    = out_result;
        wr_n     = 1'b0;
        launch   = 1'b0;
        resolved = 1'b0;
        finish   = 1'b0;

        if (data_acc && wcnt != 3'd7)
            wcnt_n = wcnt + 3'd1;
        if (eop_now)
            eop_n = 1'b1;

        case (state)
            S_IDLE: begin
                if (data_acc)
                    state_n = S_HDR;
            end
            S_HDR: begin
                if (eop_now) begin
                    res_n  = NON_IP_RESULT;
                    finish = 1'b1;
                end else if (data_acc) begin
                    if (wcnt == WORD_ETHTYPE &&
                        (in_data[31:16] != ETH_TYPE_IP || in_data[15:12] != IP_VERSION_4)) begin
                        res_n   = NON_IP_RESULT;
                        state_n = S_TAIL;
                    end else if (wcnt == WORD_KEY) begin
                        if (KEY_SEL == 0) begin
                            key_n  = in_data[47:16];
                            launch = 1'b1;
                        end else begin
                            key_n = {in_data[15:0], lookup_key[15:0]};
                        end
                    end else if (wcnt == WORD_KEY_LO && KEY_SEL != 0) begin
                        key_n  = {lookup_key[31:16], in_data[63:48]};
                        launch = 1'b1;
                    end
                end
            end
            S_REQ: launch = 1'b1;
            S_WAIT: begin
                if (lookup_done) begin
                    res_n    = lookup_hit;
                    resolved = 1'b1;
                end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                    res_n    = TIMEOUT_RESULT;
                    resolved = 1'b1;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            S_TAIL: begin
                if (eop_now)
                    finish = 1'b1;
            end
            S_EMIT: begin
                if (out_result_rdy) begin
                    wr_n    = 1'b1;
                    state_n = S_IDLE;
                    eop_n   = 1'b0;
                    wcnt_n  = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (launch) begin
            if (!lookup_busy) begin
                req_n   = 1'b1;
                tcnt_n  = '0;
                state_n = S_WAIT;
            end else begin
                state_n = S_REQ;
            end
        end

        // EOP and lookup completion may arrive in either order
        if (resolved) begin
            if (eop_seen || eop_now)
                finish = 1'b1;
            else
                state_n = S_TAIL;
        end

        if (finish) begin
            if (out_result_rdy) begin
                wr_n    = 1'b1;
                state_n = S_IDLE;
                eop_n   = 1'b0;
                wcnt_n  = '0;
            end else begin
                state_n = S_EMIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            wcnt          <= '0;
            eop_seen      <= 1'b0;
            lookup_key    <= '0;
            lookup_req    <= 1'b0;
            tcnt          <= '0;
            out_result    <= 1'b0;
            out_result_wr <= 1'b0;
        end else begin
            state         <= state_n;
            wcnt          <= wcnt_n;
            eop_seen      <= eop_n;
            lookup_key    <= key_n;
            lookup_req    <= req_n;
            tcnt          <= tcnt_n;
            out_result    <= res_n;
            out_result_wr <= wr_n;
        end
    end

endmodule

// File: tb/tb_fw_hdr_lookup.sv
// Directed bench for fw_hdr_lookup: per-scenario tasks with hand-computed expectations.
module tb_fw_hdr_lookup;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic        lookup_req;
    logic [31:0] lookup_key;
    logic        lookup_busy = 1'b0;
    logic        lookup_done = 1'b0;
    logic        lookup_hit = 1'b0;
    logic        out_result;
    logic        out_result_wr;
    logic        out_result_rdy = 1'b1;

    logic        d1_in_rdy, d1_req, d1_res, d1_wr;
    logic [31:0] d1_key;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drive_cyc = 0;
    int req_cnt = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    logic wr_val = 1'b0;
    logic res_arr [0:63];

    always #5 clk = ~clk;

    fw_hdr_lookup #(
        .DATA_WIDTH(64), .KEY_SEL(0), .NON_IP_RESULT(1'b0),
        .TIMEOUT_CYCLES(16), .TIMEOUT_RESULT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(in_rdy), .lookup_req(lookup_req),
        .lookup_key(lookup_key), .lookup_busy(lookup_busy),
        .lookup_done(lookup_done), .lookup_hit(lookup_hit),
        .out_result(out_result), .out_result_wr(out_result_wr),
        .out_result_rdy(out_result_rdy)
    );

    // Destination-key instance with an idle TCAM; only its key is inspected
    fw_hdr_lookup #(.DATA_WIDTH(64), .KEY_SEL(1)) dut_dst (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(d1_in_rdy), .lookup_req(d1_req),
        .lookup_key(d1_key), .lookup_busy(1'b0),
        .lookup_done(1'b0), .lookup_hit(1'b0),
        .out_result(d1_res), .out_result_wr(d1_wr),
        .out_result_rdy(1'b1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lookup_req)
            req_cnt <= req_cnt + 1;
        if (out_result_wr) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
            wr_val <= out_result;
            if (wr_cnt < 64)
                res_arr[wr_cnt] <= out_result;
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] d, input logic [7:0] c);
        int n = 0;
        while (!in_rdy && n < 200) begin
            step;
            n++;
        end
        if (!in_rdy) begin
            $display("FAIL put_wait in_rdy=%0b required=1", in_rdy);
            bad++;
            total++;
        end
        in_data   = d;
        in_ctrl   = c;
        in_wr     = 1'b1;
        drive_cyc = cyc;
        step;
        in_wr     = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] eth, input logic [31:0] src,
                            input logic [31:0] dst, input bit busy_pulse,
                            output int key_cyc, output int eop_cyc);
        put(64'hAAAA_0000_0000_0001, 8'hFF);
        put(64'h0011_2233_4455_6677, 8'h00);
        put({32'h8899_AABB, eth, 16'h4500}, 8'h00);
        put(64'h0000_0000_4000_4006, 8'h00);
        if (busy_pulse)
            lookup_busy = 1'b1;
        put({16'h4011, src, dst[31:16]}, 8'h00);
        key_cyc = drive_cyc;
        put({dst[15:0], 48'h0}, 8'h00);
        lookup_busy = 1'b0;
        put(64'h0, 8'h01);
        eop_cyc = drive_cyc;
    endtask

    task automatic respond(input int dly, input logic hit, input bit en,
                           output int rc, output int dc);
        int base = req_cnt;
        int n = 0;
        rc = -1;
        dc = -1;
        while (req_cnt == base && n < 200) begin
            step;
            n++;
        end
        if (req_cnt == base) begin
            $display("FAIL req_wait req_cnt=%0d required=%0d", req_cnt, base + 1);
            bad++;
            total++;
        end else begin
            rc = cyc;
            if (en) begin
                repeat (dly) step;
                lookup_done = 1'b1;
                lookup_hit  = hit;
                dc = cyc;
                step;
                lookup_done = 1'b0;
                lookup_hit  = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        step;
        total++;
        if ({in_rdy, lookup_req, lookup_key, out_result, out_result_wr} !== 36'h0) begin
            $display("FAIL reset_outputs got rdy=%0b req=%0b key=%h res=%0b wr=%0b required all 0",
                     in_rdy, lookup_req, lookup_key, out_result, out_result_wr);
            bad++;
        end
        reset = 1'b0;
        step;
        total++;
        if (in_rdy !== 1'b1) begin
            $display("FAIL reset_release in_rdy=%0b required=1", in_rdy);
            bad++;
        end
    endtask

    task automatic test_ip_hit;
        int r0 = req_cnt, w0 = wr_cnt, kc, ec, rc, dc;
        fork
            send_pkt(16'h0800, 32'h0A00_0001, 32'hC0A8_0102, 1'b0, kc, ec);
            respond(3, 1'b1, 1'b1, rc, dc);
        join
        repeat (3) step;
        total++;
        if (lookup_key !== 32'h0A00_0001) begin
            $display("FAIL hit_key got=%h required=0a000001", lookup_key);
            bad++;
        end
        total++;
        if (req_cnt - r0 !== 1) begin
            $display("FAIL hit_req_count got=%0d required=1", req_cnt - r0);
            bad++;
        end
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b1) begin
            $display("FAIL hit_result writes=%0d val=%0b required 1 write val=1", wr_cnt - w0, wr_val);
            bad++;
        end
        total++;
        if (wr_cyc !== dc + 1) begin
            $display("FAIL hit_latency wr_cyc=%0d required=%0d", wr_cyc, dc + 1);
            bad++;
        end
        total++;
        if (rc !== kc + 1) begin
            $display("FAIL req_latency req_cyc=%0d required=%0d", rc, kc + 1);
            bad++;
        end
        repeat (25) step;
        total++;
        if (d1_key !== 32'hC0A8_0102) begin
            $display("FAIL dst_key got=%h required=c0a80102", d1_key);
            bad++;
        end
    endtask

    task automatic test_arp;
        int r0 = req_cnt, w0 = wr_cnt, kc, ec;
        send_pkt(16'h0806, 32'h0A00_0001, 32'h0A00_0002, 1'b0, kc, ec);
        repeat (3) step;
        total++;
        if (req_cnt !== r0) begin
            $display("FAIL arp_no_req got=%0d required=0", req_cnt - r0);
            bad++;
        end
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b0) begin
            $display("FAIL arp_result writes=%0d val=%0b required 1 write val=0", wr_cnt - w0, wr_val);
            bad++;
        end
        total++;
        if (wr_cyc !== ec + 1) begin
            $display("FAIL arp_latency wr_cyc=%0d required=%0d", wr_cyc, ec + 1);
            bad++;
        end
    endtask

    task automatic test_word_path;
        int w0 = wr_cnt, kc, ec, rc, dc;
        fork
            send_pkt(16'h0800, 32'h0A00_0003, 32'h0A00_0004, 1'b0, kc, ec);
            respond(0, 1'b0, 1'b1, rc, dc);
        join
        repeat (3) step;
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b0 || wr_cyc !== ec + 1) begin
            $display("FAIL word_path writes=%0d val=%0b cyc=%0d required 1/0/%0d",
                     wr_cnt - w0, wr_val, wr_cyc, ec + 1);
            bad++;
        end
    endtask

    task automatic test_timeout;
        int w0 = wr_cnt, kc, ec, rc, dc, n = 0;
        fork
            send_pkt(16'h0800, 32'h0A00_0005, 32'h0A00_0006, 1'b0, kc, ec);
            respond(0, 1'b0, 1'b0, rc, dc);
        join
        while (wr_cnt == w0 && n < 40) begin
            step;
            n++;
        end
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b1 || wr_cyc - rc !== 17) begin
            $display("FAIL timeout writes=%0d val=%0b delay=%0d required 1/1/17",
                     wr_cnt - w0, wr_val, wr_cyc - rc);
            bad++;
        end
        lookup_done = 1'b1;
        lookup_hit  = 1'b0;
        step;
        lookup_done = 1'b0;
        repeat (3) step;
        total++;
        if (wr_cnt - w0 !== 1 || in_rdy !== 1'b1) begin
            $display("FAIL late_done writes=%0d rdy=%0b required 1/1", wr_cnt - w0, in_rdy);
            bad++;
        end
    endtask

    task automatic test_rdy_stall;
        int w0 = wr_cnt, kc, ec, rc, dc, c;
        int stall_bad = 0;
        out_result_rdy = 1'b0;
        fork
            send_pkt(16'h0800, 32'h0A00_0007, 32'h0A00_0008, 1'b0, kc, ec);
            respond(0, 1'b1, 1'b1, rc, dc);
        join
        for (int i = 0; i < 10; i++) begin
            step;
            total++;
            if (in_rdy !== 1'b0 || wr_cnt !== w0) begin
                $display("FAIL stall_hold cycle=%0d rdy=%0b writes=%0d required 0/0",
                         i, in_rdy, wr_cnt - w0);
                bad++;
                stall_bad++;
            end
        end
        out_result_rdy = 1'b1;
        c = cyc;
        step;
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b1 || wr_cyc !== c + 1) begin
            $display("FAIL stall_release writes=%0d val=%0b cyc=%0d required 1/1/%0d",
                     wr_cnt - w0, wr_val, wr_cyc, c + 1);
            bad++;
        end
    endtask

    task automatic test_back_to_back;
        int w0 = wr_cnt, r0 = req_cnt;
        int kc0, kc1, kc2, ec0, ec1, ec2;
        int rq0, rq1, rq2, dq0, dq1, dq2;
        fork
            begin
                send_pkt(16'h0800, 32'h0A00_0011, 32'h0, 1'b0, kc0, ec0);
                send_pkt(16'h0800, 32'h0A00_0012, 32'h0, 1'b1, kc1, ec1);
                send_pkt(16'h0800, 32'h0A00_0013, 32'h0, 1'b0, kc2, ec2);
            end
            begin
                respond(2, 1'b1, 1'b1, rq0, dq0);
                respond(2, 1'b0, 1'b1, rq1, dq1);
                respond(2, 1'b1, 1'b1, rq2, dq2);
            end
        join
        repeat (5) step;
        total++;
        if (wr_cnt - w0 !== 3 || req_cnt - r0 !== 3) begin
            $display("FAIL b2b_counts writes=%0d reqs=%0d required 3/3", wr_cnt - w0, req_cnt - r0);
            bad++;
        end
        total++;
        if ({res_arr[w0], res_arr[w0+1], res_arr[w0+2]} !== 3'b101) begin
            $display("FAIL b2b_order got=%b%b%b required=101", res_arr[w0], res_arr[w0+1], res_arr[w0+2]);
            bad++;
        end
        total++;
        if (rq1 !== kc1 + 3) begin
            $display("FAIL b2b_busy_req req_cyc=%0d required=%0d", rq1, kc1 + 3);
            bad++;
        end
    endtask

    task automatic test_reset_mid_wait;
        int w0, kc, ec, rc, dc;
        fork
            send_pkt(16'h0800, 32'h0A00_0021, 32'h0, 1'b0, kc, ec);
            respond(0, 1'b0, 1'b0, rc, dc);
        join
        repeat (3) step;
        reset = 1'b1;
        #1;
        total++;
        if ({in_rdy, lookup_req, lookup_key, out_result, out_result_wr} !== 36'h0) begin
            $display("FAIL reset_mid got rdy=%0b req=%0b key=%h res=%0b wr=%0b required all 0",
                     in_rdy, lookup_req, lookup_key, out_result, out_result_wr);
            bad++;
        end
        repeat (2) step;
        reset = 1'b0;
        w0 = wr_cnt;
        repeat (25) step;
        total++;
        if (wr_cnt !== w0) begin
            $display("FAIL reset_abort writes=%0d required=0", wr_cnt - w0);
            bad++;
        end
        fork
            send_pkt(16'h0800, 32'h0A00_00FF, 32'h0, 1'b0, kc, ec);
            respond(1, 1'b0, 1'b1, rc, dc);
        join
        repeat (3) step;
        total++;
        if (wr_cnt - w0 !== 1 || wr_val !== 1'b0 || lookup_key !== 32'h0A00_00FF) begin
            $display("FAIL reset_next writes=%0d val=%0b key=%h required 1/0/0a0000ff",
                     wr_cnt - w0, wr_val, lookup_key);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_ip_hit();
        test_arp();
        test_word_path();
        test_timeout();
        test_rdy_stall();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
